// File: rtl/leddc_pwm_core_if.sv
// leddc_pwm_core_if: frame-memory write port and bank-swap handshake of the PWM core
interface leddc_pwm_core_if #(
    parameter int AW      = 9,
    parameter int GS_BITS = 16
);
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [GS_BITS-1:0] wr_data;
    logic               swap_req;
    logic               swap_ack;

    modport master (output wr_en, wr_addr, wr_data, swap_req, input swap_ack);
    modport slave  (input wr_en, wr_addr, wr_data, swap_req, output swap_ack);
endinterface

// File: rtl/leddc_pwm_core.sv
// leddc_pwm_core: double-buffered grayscale PWM engine (normal/scrambled) in the GCK domain.
// Define LEDDC_CH_MASK_EN to add a per-channel output mask latched at scanline start.
module leddc_pwm_core #(
    parameter int CH       = 16,
    parameter int GS_BITS  = 16,
    parameter int SCAN     = 32,
    parameter int ROUNDS   = 2,
    parameter int SEG_BITS = 4,
    localparam int SW      = SCAN > 1 ? $clog2(SCAN) : 1
) (
    input  logic          GCK,
    input  logic          rst,
    input  logic          Vsync,
    input  logic          mode,
`ifdef LEDDC_CH_MASK_EN
    input  logic [CH-1:0] ch_mask,
`endif
    leddc_pwm_core_if.slave bus,
    output logic [CH-1:0] OUT,
    output logic [SW-1:0] scan_idx,
    output logic          frame_done
);
    localparam int N  = SCAN * CH;
    localparam int AW = $clog2(N);
    localparam int RW = ROUNDS > 1 ? $clog2(ROUNDS) : 1;
    localparam int PW = GS_BITS - SEG_BITS;
    localparam logic [GS_BITS:0] FULL = (GS_BITS + 1)'(1) << GS_BITS;

    logic [GS_BITS-1:0] mem [2][N];
    logic [GS_BITS-1:0] line [CH];
    logic [GS_BITS:0]   cnt;
    logic [RW-1:0]      round;
    logic [AW-1:0]      row_base;
    logic [CH-1:0]      cmp, en;
    logic               active, front, pending, vs_q, scr, last;

    assign row_base = AW'(scan_idx) * AW'(CH);
    assign last     = scan_idx == SW'(SCAN - 1);

    always_ff @(posedge GCK)
        if (bus.wr_en && {1'b0, bus.wr_addr} < (AW + 1)'(N)) mem[~front][bus.wr_addr] <= bus.wr_data;

    // Scrambled mode spreads gray over 2^SEG_BITS segments; the low gray bits add one step to the first segments.
    always_comb begin
        cmp = '0;
        for (int c = 0; c < CH; c++)
            cmp[c] = scr ? {1'b0, cnt[PW-1:0]} < {1'b0, line[c][GS_BITS-1:SEG_BITS]}
                           + (PW + 1)'(cnt[GS_BITS-1 -: SEG_BITS] < line[c][SEG_BITS-1:0])
                         : cnt < {1'b0, line[c]};
    end

`ifdef LEDDC_CH_MASK_EN
    logic [CH-1:0] mask_q;
    always_ff @(posedge GCK or posedge rst)
        if (rst) mask_q <= '0;
        else if (Vsync && !vs_q) mask_q <= ch_mask;
    assign en = ~mask_q;
`else
    assign en = '1;
`endif

    always_ff @(posedge GCK or posedge rst)
        if (rst) begin
            OUT          <= '0;
            scan_idx     <= '0;
            round        <= '0;
            cnt          <= '0;
            active       <= 1'b0;
            front        <= 1'b0;
            pending      <= 1'b0;
            bus.swap_ack <= 1'b0;
            frame_done   <= 1'b0;
            vs_q         <= 1'b0;
            scr          <= 1'b0;
            for (int c = 0; c < CH; c++) line[c] <= '0;
        end else begin
            vs_q         <= Vsync;
            bus.swap_ack <= 1'b0;
            frame_done   <= 1'b0;
            if (bus.swap_req) pending <= 1'b1;
            if (Vsync && !vs_q) begin
                for (int c = 0; c < CH; c++) line[c] <= mem[front][row_base + AW'(c)];
                scr    <= mode;
                cnt    <= '0;
                active <= 1'b1;
                OUT    <= '0;
            end else if (Vsync && active) begin
                OUT <= cnt != FULL ? cmp & en : '0;
                if (cnt != FULL) cnt <= cnt + 1'b1;
            end else if (!Vsync && active) begin
                OUT      <= '0;
                active   <= 1'b0;
                scan_idx <= last ? '0 : scan_idx + 1'b1;
                if (last) begin
                    round <= round == RW'(ROUNDS - 1) ? '0 : round + 1'b1;
                    if (round == RW'(ROUNDS - 1)) begin
                        frame_done <= 1'b1;
                        // A request arriving on the frame-end edge itself is honoured here too.
                        if (pending || bus.swap_req) begin
                            front        <= ~front;
                            bus.swap_ack <= 1'b1;
                            pending      <= 1'b0;
                        end
                    end
                end
            end
        end
endmodule

// File: tb/tb_leddc_pwm_core.sv
// tb_leddc_pwm_core: driver queues hand-computed per-window pulse patterns; a monitor rebuilds them from OUT.
`timescale 1ns/1ps
module tb_leddc_pwm_core;
    localparam int CH = 4, GS = 6, SCAN = 3, ROUNDS = 2, SEG = 2, AW = 4;

    typedef struct packed {
        logic                chk;
        logic [CH-1:0][63:0] pat;
        logic [1:0]          idx;
        logic                ack;
        logic                done;
    } exp_t;

    logic          GCK = 1'b0, rst = 1'b1, vsync = 1'b0, mode = 1'b0;
    logic [CH-1:0] OUT;
    logic [1:0]    scan_idx;
    logic          frame_done;
`ifdef LEDDC_CH_MASK_EN
    logic [CH-1:0] ch_mask = '0;
`endif
    int   n_chk = 0, n_fail = 0;
    exp_t sb[$];

    leddc_pwm_core_if #(.AW(AW), .GS_BITS(GS)) bus ();

    leddc_pwm_core #(.CH(CH), .GS_BITS(GS), .SCAN(SCAN), .ROUNDS(ROUNDS), .SEG_BITS(SEG)) dut (
        .GCK       (GCK),
        .rst       (rst),
        .Vsync     (vsync),
        .mode      (mode),
`ifdef LEDDC_CH_MASK_EN
        .ch_mask   (ch_mask),
`endif
        .bus       (bus),
        .OUT       (OUT),
        .scan_idx  (scan_idx),
        .frame_done(frame_done)
    );

    always #5 GCK = ~GCK;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] ones(input int g);
        return g >= 64 ? '1 : (64'd1 << g) - 64'd1;
    endfunction

    function automatic exp_t mk(input logic chk, input logic [63:0] p0, p1, p2, p3,
                                input int idx, input logic ack, input logic done);
        exp_t e;
        e.chk = chk;
        e.pat = {p3, p2, p1, p0};
        e.idx = 2'(idx);
        e.ack = ack;
        e.done = done;
        return e;
    endfunction

    task automatic wr(input int a, input int d);
        bus.wr_en = 1'b1;
        bus.wr_addr = AW'(a);
        bus.wr_data = GS'(d);
        @(posedge GCK); #2;
        bus.wr_en = 1'b0;
    endtask

    task automatic swap_pulse();
        bus.swap_req = 1'b1;
        @(posedge GCK); #2;
        bus.swap_req = 1'b0;
    endtask

    // n edges see Vsync high (E0 plus n-1 steps); mode flips after E0 to prove it was latched.
    task automatic window(input int n, input logic m, input exp_t e);
        sb.push_back(e);
        mode = m;
        vsync = 1'b1;
        @(posedge GCK); #2;
        mode = ~m;
        repeat (n - 1) @(posedge GCK);
        #2;
        vsync = 1'b0;
        repeat (2) @(posedge GCK);
        #2;
        mode = 1'b0;
    endtask

    initial begin
        logic vs, pv, cap;
        int step;
        logic [CH-1:0][63:0] pat;
        logic [CH-1:0] over;
        exp_t e;
        pv = 1'b0; cap = 1'b0; step = 0; pat = '0; over = '0;
        forever begin
            @(posedge GCK);
            vs = vsync;
            @(negedge GCK);
            if (rst) begin
                cap = 1'b0;
                pv = 1'b0;
            end else begin
                if (vs && !pv) begin
                    cap = 1'b1; step = 0; pat = '0; over = '0;
                end else if (vs && cap) begin
                    step++;
                    for (int c = 0; c < CH; c++)
                        if (OUT[c]) begin
                            if (step <= 64) pat[c][step-1] = 1'b1;
                            else over[c] = 1'b1;
                        end
                end else if (!vs && cap) begin
                    cap = 1'b0;
                    if (sb.size() == 0) check("unexpected_window", 64'd1, 64'd0);
                    else begin
                        e = sb.pop_front();
                        if (e.chk) begin
                            for (int c = 0; c < CH; c++) check($sformatf("pattern_ch%0d", c), pat[c], e.pat[c]);
                            check("high_after_window_full", 64'(over), 64'd0);
                        end
                        check("out_at_end", 64'(OUT), 64'd0);
                        check("scan_idx", 64'(scan_idx), 64'(e.idx));
                        check("swap_ack", 64'(bus.swap_ack), 64'(e.ack));
                        check("frame_done", 64'(frame_done), 64'(e.done));
                    end
                end
                pv = vs;
            end
        end
    end

    initial begin
        int d1 [3][4] = '{'{0, 1, 32, 63}, '{19, 19, 5, 0}, '{40, 10, 63, 7}};
        logic [63:0] w9c0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.swap_req = 1'b0;
        repeat (3) @(posedge GCK);
        #2;
        rst = 1'b0;
        check("reset_out", 64'(OUT), 64'd0);
        check("reset_scan_idx", 64'(scan_idx), 64'd0);
        check("reset_swap_ack", 64'(bus.swap_ack), 64'd0);
        check("reset_frame_done", 64'(frame_done), 64'd0);

        // Fill bank 1 and swap it to the front after one full frame of unchecked windows.
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++) wr(r * 4 + c, d1[r][c]);
        swap_pulse();
        for (int i = 0; i < 6; i++) window(3, 1'b0, mk(1'b0, 0, 0, 0, 0, (i + 1) % 3, i == 5, i == 5));

        // Bank 0 is now the back bank; out-of-range addresses must be dropped.
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++) wr(r * 4 + c, (r * 4 + c) * 3 + 2);
        wr(12, 63);
        wr(15, 63);

        window(66, 1'b0, mk(1'b1, 64'h0, 64'h1, 64'hFFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 0));
        window(66, 1'b1, mk(1'b1, 64'h000F_001F_001F_001F, 64'h000F_001F_001F_001F,
                            64'h0001_0001_0001_0003, 64'h0, 2, 0, 0));
        swap_pulse();
        repeat (3) @(posedge GCK);
        #2;
        swap_pulse();
        window(21, 1'b0, mk(1'b1, 64'hF_FFFF, 64'h3FF, 64'hF_FFFF, 64'h7F, 0, 0, 0));
        window(11, 1'b0, mk(1'b1, 64'h0, 64'h1, 64'h3FF, 64'h3FF, 1, 0, 0));
        window(11, 1'b0, mk(1'b1, 64'h3FF, 64'h3FF, 64'h1F, 64'h0, 2, 0, 0));
        window(11, 1'b0, mk(1'b1, 64'h3FF, 64'h3FF, 64'h3FF, 64'h7F, 0, 1, 1));
        window(66, 1'b0, mk(1'b1, ones(2), ones(5), ones(8), ones(11), 1, 0, 0));

        // Asynchronous reset in the middle of the row-1 window.
        vsync = 1'b1;
        repeat (11) @(posedge GCK);
        #2;
        check("pre_reset_out", 64'(OUT), 64'hF);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_out", 64'(OUT), 64'd0);
        check("async_reset_scan_idx", 64'(scan_idx), 64'd0);
        vsync = 1'b0;
        @(posedge GCK); #2;
        rst = 1'b0;
        repeat (10) @(posedge GCK);
        #2;
        check("idle_scan_idx", 64'(scan_idx), 64'd0);

        window(66, 1'b0, mk(1'b1, ones(2), ones(5), ones(8), ones(11), 1, 0, 0));
`ifdef LEDDC_CH_MASK_EN
        ch_mask = 4'b0001;
        w9c0 = 64'h0;
`else
        w9c0 = ones(14);
`endif
        window(66, 1'b0, mk(1'b1, w9c0, ones(17), ones(20), ones(23), 2, 0, 0));
`ifdef LEDDC_CH_MASK_EN
        ch_mask = '0;
`endif
        window(66, 1'b0, mk(1'b1, ones(26), ones(29), ones(32), ones(35), 0, 0, 0));

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge GCK);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
